// File: rtl/rpc2_ctrl_axi_aw_splitter.sv
// rpc2_ctrl_axi_aw_splitter
//
// Write-address front end in the AXI (wr_clk) domain. It takes one AXI AW
// request at a time and turns it into one or more sub-command words. Each
// word is pushed into the command CDC synchronizer. INCR bursts are cut at
// every 2^BOUNDARY_LOG2-byte page boundary, so the memory-side sequencer
// never sees a burst that crosses a page. WRAP, FIXED and reserved bursts
// are passed through unsplit.
//
// Ports:
//   wr_clk, wr_rst_n       clock and asynchronous active-low reset
//   s_awvalid / s_awready  AW handshake
//   s_awid, s_awaddr, s_awlen, s_awsize, s_awburst   AW request fields
//   sync_wr_en             sub-command push request (a push is en & ready)
//   sync_wr_data           sub-command word; fields from MSB to LSB are
//                          {id, addr, len, size, wrap, last}
//   sync_wr_ready          synchronizer is not full
//   busy                   high while sub-commands are being issued
module rpc2_ctrl_axi_aw_splitter #(
  parameter  int ID_WIDTH      = 4,
  parameter  int ADDR_WIDTH    = 32,
  parameter  int BOUNDARY_LOG2 = 10,
  localparam int CMD_WIDTH     = ID_WIDTH + ADDR_WIDTH + 13
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [ID_WIDTH-1:0]   s_awid,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic [7:0]            s_awlen,
  input  logic [2:0]            s_awsize,
  input  logic [1:0]            s_awburst,
  output logic                  sync_wr_en,
  output logic [CMD_WIDTH-1:0]  sync_wr_data,
  input  logic                  sync_wr_ready,
  output logic                  busy
);

  // beats_to_boundary can reach 2^BOUNDARY_LOG2 (size 0, page-aligned
  // address), so it needs one bit more than the page offset. It is compared
  // against the 9-bit remaining-beat count, so the comparison uses the
  // wider of the two widths.
  localparam int BTB_W = BOUNDARY_LOG2 + 1;
  localparam int CMP_W = (BTB_W > 9) ? BTB_W : 9;

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  state_t                  state;
  logic [ID_WIDTH-1:0]     cur_id;
  logic [2:0]              cur_size;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [8:0]              cur_rem;

  logic [ADDR_WIDTH-1:0]   calc_addr;
  logic [8:0]              calc_rem;
  logic [2:0]              calc_size;
  logic [ADDR_WIDTH-1:0]   size_mask;
  logic [ADDR_WIDTH-1:0]   abase;
  logic [BTB_W-1:0]        btb;
  logic [8:0]              beats;
  logic [7:0]              sub_len;
  logic                    sub_last;
  logic [ADDR_WIDTH-1:0]   next_addr;

  // Split arithmetic for the sub-command about to be loaded. In IDLE it
  // works on the incoming AW request. In ISSUE it works on the stored
  // address and beat count of the burst in progress. The sub-command ends
  // at the first page boundary or when the burst runs out, whichever is
  // sooner. next_addr is the aligned start of the following piece.
  always_comb begin
    calc_addr = cur_addr;
    calc_rem  = cur_rem;
    calc_size = cur_size;
    if (state == IDLE) begin
      calc_addr = s_awaddr;
      calc_rem  = {1'b0, s_awlen} + 9'd1;
      calc_size = s_awsize;
    end
    size_mask = (ADDR_WIDTH'(1) << calc_size) - ADDR_WIDTH'(1);
    abase     = calc_addr & ~size_mask;
    btb       = ((BTB_W'(1) << BOUNDARY_LOG2) - BTB_W'(abase[BOUNDARY_LOG2-1:0])) >> calc_size;
    beats     = (CMP_W'(calc_rem) < CMP_W'(btb)) ? calc_rem : 9'(btb);
    sub_last  = (beats == calc_rem);
    sub_len   = 8'(beats - 9'd1);
    next_addr = abase + (ADDR_WIDTH'(beats) << calc_size);
  end

  // Control FSM. All outputs are registered.
  // IDLE accepts a request and loads its first sub-command right away, so
  // sync_wr_en rises in the cycle after the AW handshake.
  // ISSUE holds the word until the synchronizer takes it. It then loads
  // the next piece with no bubble, or returns to IDLE after the last one.
  // Any word left in sync_wr_data after the final push is harmless, because
  // sync_wr_en is low by then.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state        <= IDLE;
      s_awready    <= 1'b1;
      sync_wr_en   <= 1'b0;
      sync_wr_data <= '0;
      busy         <= 1'b0;
      cur_id       <= '0;
      cur_size     <= '0;
      cur_addr     <= '0;
      cur_rem      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_awvalid) begin
            state      <= ISSUE;
            s_awready  <= 1'b0;
            sync_wr_en <= 1'b1;
            busy       <= 1'b1;
            cur_id     <= s_awid;
            cur_size   <= s_awsize;
            if (s_awburst == 2'b01) begin
              sync_wr_data <= {s_awid, s_awaddr, sub_len, s_awsize, 1'b0, sub_last};
              cur_addr     <= next_addr;
              cur_rem      <= calc_rem - beats;
            end else begin
              sync_wr_data <= {s_awid, s_awaddr, s_awlen, s_awsize, (s_awburst == 2'b10), 1'b1};
              cur_addr     <= s_awaddr;
              cur_rem      <= '0;
            end
          end
        end
        ISSUE: begin
          if (sync_wr_ready) begin
            if (sync_wr_data[0]) begin
              state      <= IDLE;
              s_awready  <= 1'b1;
              sync_wr_en <= 1'b0;
              busy       <= 1'b0;
            end else begin
              sync_wr_data <= {cur_id, cur_addr, sub_len, cur_size, 1'b0, sub_last};
              cur_addr     <= next_addr;
              cur_rem      <= cur_rem - beats;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rpc2_ctrl_axi_aw_splitter.md
Name: rpc2_ctrl_axi_aw_splitter

Overview:
Write-address front end in the AXI (wr_clk) domain, directly upstream of the 2-entry command CDC synchronizer.
- Accepts one AXI AW request at a time.
- Splits INCR bursts at a fixed device page boundary into sub-commands.
- Pushes each sub-command word into the synchronizer's write port (wr_en/wr_data/wr_ready semantics: a push occurs when en & ready).
- The memory-side sequencer then never has to handle a burst that crosses a page.

Parameters:
ID_WIDTH, 4, AXI ID width
ADDR_WIDTH, 32, AXI address width
BOUNDARY_LOG2, 10, log2 of split boundary in bytes; legal range 7..12
CMD_WIDTH, ID_WIDTH+ADDR_WIDTH+13, sub-command word width (derived, must not be overridden)

Ports:
wr_clk  in  1  AXI/write-side clock
wr_rst_n  in  1  asynchronous, active-low reset
s_awvalid  in  1  AW request valid
s_awready  out  1  AW request ready
s_awid  in  ID_WIDTH  AW ID
s_awaddr  in  ADDR_WIDTH  AW start address
s_awlen  in  8  beats-1
s_awsize  in  3  log2 bytes per beat
s_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP
sync_wr_en  out  1  sub-command push request to synchronizer
sync_wr_data  out  CMD_WIDTH  sub-command word
sync_wr_ready  in  1  synchronizer not full
busy  out  1  high whenever state is ISSUE

Behaviour:
- Reset values: s_awready=1, sync_wr_en=0, sync_wr_data=0, busy=0; state=IDLE.
- Reset is asynchronous, active-low on wr_rst_n; clock is wr_clk.
- sync_wr_data packing, MSB→LSB: id[ID_WIDTH], addr[ADDR_WIDTH], len[8] (beats-1), size[3], wrap[1], last[1].
- All outputs are registered.
- FSM states: IDLE, ISSUE.
- IDLE:
  - s_awready=1.
  - On s_awvalid: capture the request, load the first sub-command into the output register, set sync_wr_en=1, go to ISSUE.
  - AW handshake at edge N → sync_wr_en high from cycle N+1.
- ISSUE:
  - s_awready=0. sync_wr_en stays high.
  - sync_wr_data is held stable while sync_wr_ready=0; no timeout.
  - On an edge with sync_wr_ready=1 and last=1: go to IDLE, sync_wr_en=0; s_awready is high in the next cycle.
  - On an edge with sync_wr_ready=1 and last=0: load the next sub-command into the output register. sync_wr_en stays high, so sub-commands are back-to-back with no bubble.
- Split arithmetic (INCR):
  - Total beats = awlen+1 (9-bit).
  - abase = current address with the low size bits cleared.
  - beats_to_boundary = (2^BOUNDARY_LOG2 − abase[BOUNDARY_LOG2-1:0]) >> size. Width is BOUNDARY_LOG2+1 bits; it may exceed 256.
  - Sub-command beats = min(remaining, beats_to_boundary); len = beats−1.
  - last = (beats == remaining).
  - First sub-command addr = original s_awaddr, unaligned kept. Later sub-commands use addr = abase + (beats << size), i.e. boundary-aligned.
  - remaining −= beats.
  - A burst that does not cross the boundary yields exactly one command with last=1 and the address unchanged.
- WRAP: issued unsplit as one command; addr, len, size unchanged; wrap=1, last=1.
- FIXED and reserved 11: issued unsplit as one command; wrap=0, last=1.
- id and size are replicated unchanged in every sub-command of a burst.
- Maximum sub-commands per burst: 256 (size 0 with a boundary smaller than the burst is bounded by beats).
- Address arithmetic wraps modulo 2^ADDR_WIDTH; no error is raised.
- Reset mid-burst: the in-progress burst is abandoned and all state clears immediately; any unpushed sub-commands are lost.
- s_awvalid is ignored in ISSUE; a held request is accepted in the first IDLE cycle.
- busy = (state == ISSUE).

Test Plan:
- Reset with s_awvalid=1 held → during reset s_awready=1, sync_wr_en=0; first post-reset edge accepts the request, sync_wr_en=1 the following cycle.
- INCR crossing, BOUNDARY_LOG2=10: addr=0x3F0, size=2, len=15, id=5, sync_wr_ready=1 → two consecutive pushes:
  - push 1: {id5, 0x3F0, len3, size2, wrap0, last0}
  - push 2: {id5, 0x400, len11, size2, wrap0, last1}
  - s_awready returns high the cycle after push 2.
- Unaligned byte burst: addr=0x3FF, size=0, len=255 → push 1 {0x3FF, len0, last0}, push 2 {0x400, len254, last1}; beat total = 256.
- Backpressure: same stimulus as the crossing scenario, sync_wr_ready=0 for 5 cycles → sync_wr_data constant and sync_wr_en high throughout; pushes resume unchanged when ready=1.
- WRAP addr=0x3F8, len=7, size=2 crossing the boundary → single push {0x3F8, len7, size2, wrap1, last1}.
- Reset asserted between push 1 and push 2 of the crossing burst → outputs return to reset values asynchronously; no further push after release until a new AW request.
